// File: rtl/t03_timer_pkg.sv
// Shared types and constants for the tick timer: FSM states, register map and CTRL bit layout.
package t03_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } timer_state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COMPARE = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_ELAPSED = 2'd3;

  localparam int EN_BIT    = 0;
  localparam int PER_BIT   = 1;
  localparam int IRQEN_BIT = 2;

endpackage

// File: rtl/t03_tick_edge_detect.sv
// Turns the free-running hardware tick count into a one-cycle tick pulse per observed change.
module t03_tick_edge_detect #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tick_count,
  output logic             tick
);

  logic [WIDTH-1:0] prev_tick;
  logic             primed;

  // The first cycle out of reset only captures the count, so no spurious tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_tick <= '0;
      primed    <= 1'b0;
    end else begin
      prev_tick <= tick_count;
      primed    <= 1'b1;
    end
  end

  assign tick = primed && (tick_count != prev_tick);

endmodule

// File: rtl/t03_tick_timer.sv
// Programmable one-shot/periodic tick timer with a four-register bus port and level interrupt.
module t03_tick_timer
  import t03_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tick_count,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             irq
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] compare_q;
  logic [WIDTH-1:0] elapsed_q, elapsed_d, elapsed_inc;
  logic             periodic_q, irq_en_q;
  logic             pending_q, pending_d;
  logic             tick, fire, wr_ctrl;
  logic [WIDTH-1:0] rd_word;

  t03_tick_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clk       (clk),
    .rst       (rst),
    .tick_count(tick_count),
    .tick      (tick)
  );

  assign wr_ctrl     = wr_en && (addr == ADDR_CTRL);
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + 1'b1;

  // Tick processing first; a CTRL write then overrides it (disable freezes elapsed,
  // enable from a non-armed state restarts the count).
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    fire      = 1'b0;
    if (state_q == ARMED && tick) begin
      elapsed_d = elapsed_inc;
      if (compare_q != '0 && elapsed_inc >= compare_q) begin
        fire = 1'b1;
        if (periodic_q) begin
          elapsed_d = '0;
        end else begin
          elapsed_d = compare_q;
          state_d   = DONE;
        end
      end
    end
    if (wr_ctrl) begin
      if (!wdata[EN_BIT]) begin
        state_d   = IDLE;
        elapsed_d = elapsed_q;
        fire      = 1'b0;
      end else if (state_q != ARMED) begin
        state_d   = ARMED;
        elapsed_d = '0;
      end
    end
    pending_d = pending_q;
    if (wr_en && addr == ADDR_STATUS && wdata[0]) pending_d = 1'b0;
    if (fire) pending_d = 1'b1;
  end

  // CTRL.enable is not stored: it reads as "currently armed".
  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_word[EN_BIT]    = (state_q == ARMED);
        rd_word[PER_BIT]   = periodic_q;
        rd_word[IRQEN_BIT] = irq_en_q;
      end
      ADDR_COMPARE: rd_word = compare_q;
      ADDR_STATUS:  rd_word[0] = pending_q;
      default:      rd_word = elapsed_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      compare_q  <= '0;
      elapsed_q  <= '0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      pending_q <= pending_d;
      if (wr_ctrl) begin
        periodic_q <= wdata[PER_BIT];
        irq_en_q   <= wdata[IRQEN_BIT];
      end
      if (wr_en && addr == ADDR_COMPARE) compare_q <= wdata;
      if (rd_en) rdata <= rd_word;
      rvalid <= rd_en;
      irq    <= pending_q & irq_en_q;
    end
  end

endmodule

// File: tb/tb_t03_tick_timer.sv
// Scoreboard bench for t03_tick_timer: directed scenarios followed by randomized register/tick traffic.
module tb_t03_tick_timer;
  import t03_timer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] tick_count = 32'h5;
  logic         wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]   addr = 2'd0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         rvalid, irq;

  t03_tick_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .tick_count(tick_count), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] rq[$];
  bit           iq[$];
  logic [W-1:0] hold_exp = '0;
  logic [W-1:0] tcv = 32'h5;

  // Reference model: timer state described as plain variables.
  bit           m_primed, m_armed, m_per, m_ie, m_pend;
  logic [W-1:0] m_prev, m_cmp, m_el;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_primed = 0; m_armed = 0; m_per = 0; m_ie = 0; m_pend = 0;
    m_prev = '0; m_cmp = '0; m_el = '0;
  endtask

  function automatic logic [W-1:0] model_read(logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ie, m_per, m_armed};
      2'd1:    return m_cmp;
      2'd2:    return {31'd0, m_pend};
      default: return m_el;
    endcase
  endfunction

  task automatic model_step(bit wr, logic [1:0] a, logic [W-1:0] wd, logic [W-1:0] tc);
    bit ticked, fired, arm_n, per_n, ie_n, pend_n;
    logic [W-1:0] el_n, cmp_n;
    ticked = m_primed && (tc != m_prev);
    m_prev = tc; m_primed = 1;
    fired = 0; arm_n = m_armed; per_n = m_per; ie_n = m_ie; pend_n = m_pend;
    el_n = m_el; cmp_n = m_cmp;
    if (m_armed && ticked) begin
      el_n = (m_el == 32'hFFFF_FFFF) ? m_el : m_el + 32'd1;
      if (m_cmp != 0 && el_n >= m_cmp) begin
        fired = 1;
        if (m_per) el_n = 0;
        else begin el_n = m_cmp; arm_n = 0; end
      end
    end
    if (wr) begin
      case (a)
        2'd0: begin
          per_n = wd[1]; ie_n = wd[2];
          if (!wd[0]) begin arm_n = 0; el_n = m_el; fired = 0; end
          else if (!m_armed) begin arm_n = 1; el_n = 0; end
        end
        2'd1: cmp_n = wd;
        2'd2: if (wd[0]) pend_n = 0;
        default: ;
      endcase
    end
    if (fired) pend_n = 1;
    m_armed = arm_n; m_per = per_n; m_ie = ie_n; m_pend = pend_n; m_el = el_n; m_cmp = cmp_n;
  endtask

  // One bus cycle: drive at negedge, predict the response, advance the model.
  task automatic cyc(bit wr, bit rd, logic [1:0] a, logic [W-1:0] wd);
    wr_en = wr; rd_en = rd; addr = a; wdata = wd; tick_count = tcv;
    if (rd) rq.push_back(model_read(a));
    iq.push_back(m_pend & m_ie);
    model_step(wr, a, wd, tcv);
    @(negedge clk);
  endtask

  task automatic idle();                               cyc(0, 0, 2'd0, '0); endtask
  task automatic wreg(logic [1:0] a, logic [W-1:0] d); cyc(1, 0, a, d);     endtask
  task automatic rreg(logic [1:0] a);                  cyc(0, 1, a, '0);    endtask
  task automatic tk();                                 tcv = tcv + 32'd1; idle(); endtask

  task automatic do_reset(string tag);
    rst = 1'b0; wr_en = 0; rd_en = 0; #1;
    check({tag, "_rdata"}, rdata, '0);
    check({tag, "_rvalid"}, {31'd0, rvalid}, '0);
    check({tag, "_irq"}, {31'd0, irq}, '0);
    rq.delete(); iq.delete(); hold_exp = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: irq every cycle, read data whenever rvalid, rdata hold otherwise.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (iq.size() > 0) check("irq", {31'd0, irq}, {31'd0, iq.pop_front()});
        if (rvalid) begin
          if (rq.size() == 0) check("rvalid_unexpected", {31'd0, rvalid}, '0);
          else begin
            hold_exp = rq.pop_front();
            check("rdata", rdata, hold_exp);
          end
        end else begin
          check("rdata_hold", rdata, hold_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   a;
    logic [W-1:0] d;
    bit           w, r;
    model_reset();
    repeat (3) @(negedge clk);
    check("por_rdata", rdata, '0);
    check("por_rvalid", {31'd0, rvalid}, '0);
    check("por_irq", {31'd0, irq}, '0);
    rst = 1'b1;

    // Constant tick count after release: no ticks, idle.
    repeat (10) idle();
    rreg(ADDR_ELAPSED); rreg(ADDR_CTRL); rreg(ADDR_STATUS);

    // One-shot, compare 3.
    wreg(ADDR_COMPARE, 32'd3);
    wreg(ADDR_CTRL, 32'b101);
    repeat (3) begin tk(); rreg(ADDR_ELAPSED); end
    rreg(ADDR_STATUS); rreg(ADDR_CTRL); idle();
    tk(); tk(); rreg(ADDR_ELAPSED);

    // Periodic, compare 2, W1C after each fire; last fire coincides with W1C.
    wreg(ADDR_COMPARE, 32'd2);
    wreg(ADDR_CTRL, 32'b111);
    wreg(ADDR_STATUS, 32'd1);
    tk(); tk(); idle(); wreg(ADDR_STATUS, 32'd1); idle();
    tk(); tk(); wreg(ADDR_STATUS, 32'd0); rreg(ADDR_STATUS); wreg(ADDR_STATUS, 32'd1); idle();
    tk(); tcv = tcv + 32'd1; cyc(1, 0, ADDR_STATUS, 32'd1);
    rreg(ADDR_STATUS); idle();

    // Lowering compare below elapsed fires on the next tick.
    wreg(ADDR_CTRL, 32'b100);
    wreg(ADDR_COMPARE, 32'd10);
    wreg(ADDR_CTRL, 32'b101);
    wreg(ADDR_STATUS, 32'd1);
    repeat (5) tk();
    wreg(ADDR_COMPARE, 32'd4);
    cyc(0, 1, ADDR_ELAPSED, '0);
    tk(); rreg(ADDR_STATUS); rreg(ADDR_ELAPSED); rreg(ADDR_CTRL);

    // Counter wrap is an ordinary tick; simultaneous read/write returns old value.
    wreg(ADDR_CTRL, 32'd0);
    wreg(ADDR_STATUS, 32'd1);
    tcv = 32'hFFFF_FFFE; idle();
    wreg(ADDR_COMPARE, 32'd2);
    cyc(1, 1, ADDR_CTRL, 32'd5);
    tk(); rreg(ADDR_ELAPSED); tk(); rreg(ADDR_STATUS); rreg(ADDR_ELAPSED); idle();

    // Reset in the middle of a count with pending set.
    wreg(ADDR_CTRL, 32'd0);
    wreg(ADDR_COMPARE, 32'd20);
    wreg(ADDR_CTRL, 32'b111);
    repeat (7) tk();
    rreg(ADDR_ELAPSED); idle();
    do_reset("midrst");
    rreg(ADDR_ELAPSED); idle(); idle();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = $urandom_range(0, 99);
      if (p < 35) tcv = tcv + 32'd1;
      else if (p < 40) tcv = tcv + $urandom;
      else if (p < 43) tcv = 32'hFFFF_FFFF - $urandom_range(0, 2);
      w = ($urandom_range(0, 99) < 15);
      r = ($urandom_range(0, 99) < 30);
      a = 2'($urandom_range(0, 3));
      case (a)
        ADDR_CTRL:    d = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
        ADDR_COMPARE: d = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
        default:      d = $urandom;
      endcase
      if ($urandom_range(0, 599) == 0) do_reset("rndrst");
      else cyc(w, r, a, d);
    end

    repeat (3) idle();
    check("rd_drain", 32'(rq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
